// File: rtl/isa_host_sequencer_pkg.sv
// Shared definitions for the ISA host sequencer and the compute-core wrapper.
// It holds the sequencer states, the control/status word bit positions and the slot write word helper.
package isa_host_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RST,
    LOAD_SETUP,
    LOAD_WE,
    LOAD_HOLD,
    START,
    WAIT_GAP,
    WAIT_DONE,
    DONE,
    ERROR
  } seq_state_t;

  localparam int unsigned SLOT_W            = 5;
  localparam int unsigned CTRL_WE           = 20;
  localparam int unsigned CTRL_ISA_SEL      = 21;
  localparam int unsigned CTRL_GRANT        = 22;
  localparam int unsigned CTRL_BRAM_SEL_LSB = 29;
  localparam int unsigned CTRL_RST          = 0;
  localparam int unsigned CTRL_START        = 1;
  localparam int unsigned STATUS_DONE       = 0;
  localparam int unsigned STATUS_CC_LSB     = 2;

  // ISA-select is always set for slot writes; grant_ext and bram_sel stay 0.
  function automatic logic [31:0] slot_word(input logic [SLOT_W-1:0] slot, input logic we);
    logic [31:0] w;
    w               = '0;
    w[SLOT_W-1:0]   = slot;
    w[CTRL_ISA_SEL] = 1'b1;
    w[CTRL_WE]      = we;
    return w;
  endfunction

endpackage

// File: rtl/isa_host_sequencer_if.sv
// Bus between the host sequencer and its instruction source and co-processor wrapper.
// The master modport is the sequencer's view; slave is the surrounding fabric.
interface isa_host_sequencer_if;
  logic        run;
  logic [5:0]  prog_len;
  logic [63:0] ins_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] control_low_word;
  logic [31:0] control_high_word;
  logic [31:0] dina_ext_low_word;
  logic [31:0] dina_ext_high_word;
  logic [31:0] status;
  logic        busy;
  logic        done;
  logic        error;
  logic [29:0] cycle_count;

  modport master (
    input  run, prog_len, ins_data, ins_valid, status,
    output ins_ready, control_low_word, control_high_word,
           dina_ext_low_word, dina_ext_high_word, busy, done, error, cycle_count
  );

  modport slave (
    output run, prog_len, ins_data, ins_valid, status,
    input  ins_ready, control_low_word, control_high_word,
           dina_ext_low_word, dina_ext_high_word, busy, done, error, cycle_count
  );
endinterface

// File: rtl/isa_host_sequencer.sv
// Host-side initiator: resets the core/ISA, loads the instruction slots, starts
// the program and waits (with a watchdog) for done_all, reporting the cycle count.
module isa_host_sequencer
  import isa_host_sequencer_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 32,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TIMEOUT_W  = 24
) (
  input logic                  clk,
  input logic                  rst_n,
  isa_host_sequencer_if.master bus
);

  localparam int unsigned RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_CYCLES - 1);
  // Watchdog is incremented to all-ones; this is the value one below that.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = ~TIMEOUT_W'(1);

  seq_state_t           state;
  logic [5:0]           len_q;
  logic [5:0]           slot_q;
  logic [RST_CNT_W-1:0] rst_cnt;
  logic                 gap_q;
  logic [TIMEOUT_W-1:0] wd_q;

  logic        ins_ready_q;
  logic [31:0] ctrl_lo_q;
  logic [31:0] ctrl_hi_q;
  logic [31:0] dina_lo_q;
  logic [31:0] dina_hi_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [29:0] cc_q;

  logic len_bad;
  logic unused_status;

  assign len_bad       = (bus.prog_len == '0) || (32'(bus.prog_len) > NUM_SLOTS);
  assign unused_status = bus.status[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_q       <= '0;
      slot_q      <= '0;
      rst_cnt     <= '0;
      gap_q       <= 1'b0;
      wd_q        <= '0;
      ins_ready_q <= 1'b0;
      ctrl_lo_q   <= '0;
      ctrl_hi_q   <= '0;
      dina_lo_q   <= '0;
      dina_hi_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cc_q        <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (bus.run) begin
            done_q <= 1'b0;
            if (len_bad) begin
              error_q <= 1'b1;
              state   <= ERROR;
            end else begin
              len_q               <= bus.prog_len;
              slot_q              <= '0;
              error_q             <= 1'b0;
              cc_q                <= '0;
              busy_q              <= 1'b1;
              rst_cnt             <= '0;
              ctrl_hi_q           <= '0;
              ctrl_hi_q[CTRL_RST] <= 1'b1;
              state               <= RST;
            end
          end
        end

        RST: begin
          if (rst_cnt == RST_LAST) begin
            ctrl_hi_q   <= '0;
            ins_ready_q <= 1'b1;
            state       <= LOAD_SETUP;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        // Address/data and the write enable are registered together so the
        // enable is visible for exactly the LOAD_WE cycle.
        LOAD_SETUP: begin
          if (bus.ins_valid && ins_ready_q) begin
            dina_lo_q   <= bus.ins_data[31:0];
            dina_hi_q   <= bus.ins_data[63:32];
            ctrl_lo_q   <= slot_word(slot_q[SLOT_W-1:0], 1'b1);
            ins_ready_q <= 1'b0;
            state       <= LOAD_WE;
          end
        end

        LOAD_WE: begin
          ctrl_lo_q <= slot_word(slot_q[SLOT_W-1:0], 1'b0);
          slot_q    <= slot_q + 1'b1;
          state     <= LOAD_HOLD;
        end

        LOAD_HOLD: begin
          ctrl_lo_q <= '0;
          if (slot_q == len_q) begin
            ctrl_hi_q             <= '0;
            ctrl_hi_q[CTRL_START] <= 1'b1;
            state                 <= START;
          end else begin
            ins_ready_q <= 1'b1;
            state       <= LOAD_SETUP;
          end
        end

        START: begin
          ctrl_hi_q <= '0;
          gap_q     <= 1'b0;
          state     <= WAIT_GAP;
        end

        WAIT_GAP: begin
          if (gap_q) begin
            wd_q  <= '0;
            state <= WAIT_DONE;
          end else begin
            gap_q <= 1'b1;
          end
        end

        // done_all is checked before the watchdog so a simultaneous finish wins.
        WAIT_DONE: begin
          if (bus.status[STATUS_DONE]) begin
            cc_q   <= bus.status[31:STATUS_CC_LSB];
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= DONE;
          end else if (wd_q == WD_LAST) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= ERROR;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ins_ready          = ins_ready_q;
  assign bus.control_low_word   = ctrl_lo_q;
  assign bus.control_high_word  = ctrl_hi_q;
  assign bus.dina_ext_low_word  = dina_lo_q;
  assign bus.dina_ext_high_word = dina_hi_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.error              = error_q;
  assign bus.cycle_count        = cc_q;

endmodule

// File: tb/tb_isa_host_sequencer.sv
// Scoreboard bench for isa_host_sequencer: slot writes and cycle counts are queued
// when driven and checked as the sequencer emits them; a short-watchdog copy covers timeout.
module tb_isa_host_sequencer;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  logic clk;
  logic rst_n;

  isa_host_sequencer_if bus();
  isa_host_sequencer_if bus_wd();

  isa_host_sequencer #(.NUM_SLOTS(32), .RST_CYCLES(4), .TIMEOUT_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  isa_host_sequencer #(.NUM_SLOTS(32), .RST_CYCLES(4), .TIMEOUT_W(4)) dut_wd (
    .clk(clk), .rst_n(rst_n), .bus(bus_wd)
  );

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int start_cnt = 0;
  int rstw_cnt = 0;

  wr_t         exp_q[$];
  logic [29:0] cc_q[$];

  logic        prev_we = 1'b0;
  logic [31:0] prev_ctrl;
  logic [63:0] prev_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input int i);
    return {32'hDEAD_0000 + 32'(i), 24'h5A5A5A, 8'hA1 + 8'(i)};
  endfunction

  // Monitor: every write-enable cycle is matched against the scoreboard, and the
  // following cycle must keep address and data with the enable dropped.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we = 1'b0;
    end else begin
      if (bus.ins_ready) begin
        check_eq("ready_ctrl_quiet", {bus.control_high_word, bus.control_low_word}, 64'h0);
        check_eq("ready_busy", bus.busy, 1'b1);
      end
      if (prev_we) begin
        check_eq("hold_ctrl", bus.control_low_word, prev_ctrl & ~32'h0010_0000);
        check_eq("hold_data", {bus.dina_ext_high_word, bus.dina_ext_low_word}, prev_data);
      end
      if (bus.control_low_word[20]) begin
        we_cnt++;
        check_eq("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check_eq("we_ctrl", bus.control_low_word, {10'b0, 1'b1, 1'b1, 15'b0, e.addr});
          check_eq("we_data", {bus.dina_ext_high_word, bus.dina_ext_low_word}, e.data);
        end
        prev_we   = 1'b1;
        prev_ctrl = bus.control_low_word;
        prev_data = {bus.dina_ext_high_word, bus.dina_ext_low_word};
      end else begin
        prev_we = 1'b0;
      end
      if (bus.control_high_word[1]) start_cnt++;
      if (bus.control_high_word[0]) rstw_cnt++;
    end
  end

  task automatic do_run(input logic [5:0] len);
    @(negedge clk);
    bus.run      = 1'b1;
    bus.prog_len = len;
    @(negedge clk);
    bus.run = 1'b0;
  endtask

  task automatic feed(input int n, input bit toggle);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 4000) begin
      @(negedge clk);
      bus.ins_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.ins_data  = word_of(idx);
      if (bus.ins_valid && bus.ins_ready) begin
        wr_t e;
        e.addr = 5'(idx);
        e.data = word_of(idx);
        exp_q.push_back(e);
        idx++;
      end
      cyc++;
    end
    @(negedge clk);
    bus.ins_valid = 1'b0;
    check_eq("feed_count", idx, n);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!bus.control_high_word[1] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("start_seen", bus.control_high_word[1], 1'b1);
  endtask

  task automatic finish_seq(input logic [29:0] cc, input int delay);
    int n = 0;
    wait_start();
    repeat (delay) @(negedge clk);
    bus.status = {cc, 2'b01};
    cc_q.push_back(cc);
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", bus.done, 1'b1);
    check_eq("cycle_count", bus.cycle_count, cc_q.pop_front());
  endtask

  initial begin
    int we0, s0, r0, n;
    bit seen;

    #500000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int we0, s0, r0, n;
    bit seen;

    rst_n = 1'b0;
    bus.run = 1'b0; bus.prog_len = '0; bus.ins_data = '0; bus.ins_valid = 1'b0; bus.status = '0;
    bus_wd.run = 1'b0; bus_wd.prog_len = '0; bus_wd.ins_data = 64'h1234_5678_9ABC_DEF0;
    bus_wd.ins_valid = 1'b1; bus_wd.status = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ctrl", {bus.control_high_word, bus.control_low_word}, 64'h0);
    check_eq("rst_dina", {bus.dina_ext_high_word, bus.dina_ext_low_word}, 64'h0);
    check_eq("rst_flags", {bus.busy, bus.done, bus.error, bus.ins_ready}, 4'h0);
    check_eq("rst_cc", bus.cycle_count, 30'h0);
    rst_n = 1'b1;

    // 1: three instructions, ins_valid always high, done 20 cycles after start
    we0 = we_cnt; s0 = start_cnt; r0 = rstw_cnt;
    do_run(6'd3);
    check_eq("t1_busy", bus.busy, 1'b1);
    check_eq("t1_rst_word", bus.control_high_word, 32'h1);
    feed(3, 1'b0);
    finish_seq(30'h123, 20);
    check_eq("t1_we_count", we_cnt - we0, 3);
    check_eq("t1_start_count", start_cnt - s0, 1);
    check_eq("t1_rst_cycles", rstw_cnt - r0, 4);
    check_eq("t1_busy_end", bus.busy, 1'b0);
    check_eq("t1_sb_empty", exp_q.size(), 0);

    // 3: stale done_all still high through reset and the wait gap
    do_run(6'd2);
    check_eq("t3_done_cleared", bus.done, 1'b0);
    feed(2, 1'b0);
    wait_start();
    check_eq("t3_no_done_load", bus.done, 1'b0);
    @(negedge clk);
    check_eq("t3_no_done_gap1", bus.done, 1'b0);
    @(negedge clk);
    check_eq("t3_no_done_gap2", bus.done, 1'b0);
    @(negedge clk);
    bus.status = 32'h0;
    check_eq("t3_no_done_wait", bus.done, 1'b0);
    repeat (4) @(negedge clk);
    bus.status = {30'h2AB, 2'b01};
    cc_q.push_back(30'h2AB);
    check_eq("t3_done_before_sample", bus.done, 1'b0);
    @(negedge clk);
    check_eq("t3_done_next", bus.done, 1'b1);
    check_eq("t3_cycle_count", bus.cycle_count, cc_q.pop_front());

    // 2: 32 instructions with ins_valid toggling
    we0 = we_cnt;
    do_run(6'd32);
    bus.status = 32'h0;
    feed(32, 1'b1);
    finish_seq(30'h3FFF_0001, 3);
    check_eq("t2_we_count", we_cnt - we0, 32);
    check_eq("t2_sb_empty", exp_q.size(), 0);

    // 4: illegal lengths
    we0 = we_cnt; s0 = start_cnt; r0 = rstw_cnt;
    do_run(6'd0);
    check_eq("t4_err_len0", bus.error, 1'b1);
    check_eq("t4_busy_len0", bus.busy, 1'b0);
    do_run(6'd40);
    check_eq("t4_err_len40", bus.error, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("t4_ctrl_quiet", {bus.control_high_word, bus.control_low_word}, 64'h0);
    check_eq("t4_no_activity", {we_cnt - we0, start_cnt - s0, rstw_cnt - r0}, 0);

    // 5: watchdog expiry with TIMEOUT_W=4, then restart clears error
    @(negedge clk);
    bus_wd.run = 1'b1; bus_wd.prog_len = 6'd1;
    @(negedge clk);
    bus_wd.run = 1'b0;
    n = 0;
    while (!bus_wd.control_high_word[1] && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_start_seen", bus_wd.control_high_word[1], 1'b1);
    repeat (17) @(negedge clk);
    check_eq("t5_no_err_early", {bus_wd.error, bus_wd.busy}, 2'b01);
    @(negedge clk);
    check_eq("t5_err", {bus_wd.error, bus_wd.busy}, 2'b10);
    check_eq("t5_ctrl_idle", {bus_wd.control_high_word, bus_wd.control_low_word}, 64'h0);
    @(negedge clk);
    bus_wd.run = 1'b1;
    @(negedge clk);
    bus_wd.run = 1'b0;
    check_eq("t5_restart", {bus_wd.error, bus_wd.busy}, 2'b01);

    // 6: asynchronous reset during LOAD_WE
    bus.status = 32'h0;
    do_run(6'd2);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.control_low_word[20]) begin
        seen = 1'b1;
      end else begin
        bus.ins_valid = 1'b1;
        bus.ins_data  = word_of(0);
        if (bus.ins_ready) begin
          wr_t e;
          e.addr = 5'd0;
          e.data = word_of(0);
          exp_q.push_back(e);
          bus.ins_valid = 1'b1;
        end
      end
    end
    check_eq("t6_we_seen", seen, 1'b1);
    #1 rst_n = 1'b0;
    bus.ins_valid = 1'b0;
    #1;
    check_eq("t6_ctrl_async_zero", {bus.control_high_word, bus.control_low_word}, 64'h0);
    check_eq("t6_busy_async_zero", {bus.busy, bus.ins_ready}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_idle_flags", {bus.busy, bus.done, bus.error, bus.ins_ready}, 4'h0);
    check_eq("t6_sb_empty", exp_q.size(), 0);
    do_run(6'd1);
    check_eq("t6_rerun_busy", bus.busy, 1'b1);
    feed(1, 1'b0);
    finish_seq(30'h0ABC, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
